// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   Execute stage of the 5-stage RISC-V pipeline together with the EX/MEM
//   pipeline register. Decodes ALU control, forwards operands from EX/MEM and
//   MEM/WB, runs the ALU, evaluates the branch condition and computes the
//   branch target, then registers everything toward the memory stage.
//
// Ports
//   clk, rst                 clock, async active-high reset (clears all regs)
//   ex_ALUOp/ALUSrc          ALU control class and operand-B select
//   ex_regReadData1/2        register-file operands
//   ex_imm, ex_pc            sign-extended immediate, PC of the EX instruction
//   ex_opcode, ex_inst_ALU   opcode and {funct7[5], funct3}
//   fd_Rs1/fd_Rs2            source register indices
//   ex_wt_*                  control bits passed through to MEM
//   wb_regWrite/ToWrite/Data MEM/WB write-back, used for forwarding
//   flush                    squash the instruction in EX (controls only)
//   mem_*                    registered EX/MEM outputs
// ---------------------------------------------------------------------------
module ex_mem_stage #(
   parameter int REG_NUM_BITWIDTH = 5,
   parameter int WORD_BITWIDTH    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  ex_ALUOp,
   input  logic                        ex_ALUSrc,
   input  logic [WORD_BITWIDTH-1:0]    ex_regReadData1,
   input  logic [WORD_BITWIDTH-1:0]    ex_regReadData2,
   input  logic [WORD_BITWIDTH-1:0]    ex_imm,
   input  logic [6:0]                  ex_opcode,
   input  logic [3:0]                  ex_inst_ALU,
   input  logic [WORD_BITWIDTH-1:0]    ex_pc,
   input  logic [REG_NUM_BITWIDTH-1:0] fd_Rs1,
   input  logic [REG_NUM_BITWIDTH-1:0] fd_Rs2,
   input  logic                        ex_wt_branch,
   input  logic                        ex_wt_memRead,
   input  logic                        ex_wt_memToReg,
   input  logic                        ex_wt_memWrite,
   input  logic                        ex_wt_regWrite,
   input  logic [REG_NUM_BITWIDTH-1:0] ex_wt_regToWrite,
   input  logic                        wb_regWrite,
   input  logic [REG_NUM_BITWIDTH-1:0] wb_regToWrite,
   input  logic [WORD_BITWIDTH-1:0]    wb_writeData,
   input  logic                        flush,
   output logic [WORD_BITWIDTH-1:0]    mem_aluResult,
   output logic [WORD_BITWIDTH-1:0]    mem_storeData,
   output logic                        mem_zero,
   output logic                        mem_branchTaken,
   output logic [WORD_BITWIDTH-1:0]    mem_branchTarget,
   output logic                        mem_wt_branch,
   output logic                        mem_wt_memRead,
   output logic                        mem_wt_memToReg,
   output logic                        mem_wt_memWrite,
   output logic                        mem_wt_regWrite,
   output logic [REG_NUM_BITWIDTH-1:0] mem_wt_regToWrite
);

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
   } alu_op_e;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;

   logic [WORD_BITWIDTH-1:0] fwd_a, fwd_b, op_b, alu_result;
   logic [2:0]               funct3;
   logic                     funct7_5;
   logic [4:0]               shamt;
   logic                     lt_s, lt_u, eq, cond;
   alu_op_e                  alu_op;

   assign funct3   = ex_inst_ALU[2:0];
   assign funct7_5 = ex_inst_ALU[3];

   // Forwarding. A load in EX/MEM has no ALU value worth forwarding (its data
   // arrives later), so memRead blocks that path; the upstream bubble then
   // lets MEM/WB supply the loaded value.
   always_comb begin
      fwd_a = ex_regReadData1;
      if (fd_Rs1 != '0) begin
         if (mem_wt_regWrite && !mem_wt_memRead && mem_wt_regToWrite == fd_Rs1)
            fwd_a = mem_aluResult;
         else if (wb_regWrite && wb_regToWrite == fd_Rs1)
            fwd_a = wb_writeData;
      end
   end

   always_comb begin
      fwd_b = ex_regReadData2;
      if (fd_Rs2 != '0) begin
         if (mem_wt_regWrite && !mem_wt_memRead && mem_wt_regToWrite == fd_Rs2)
            fwd_b = mem_aluResult;
         else if (wb_regWrite && wb_regToWrite == fd_Rs2)
            fwd_b = wb_writeData;
      end
   end

   assign op_b  = ex_ALUSrc ? ex_imm : fwd_b;
   assign shamt = op_b[4:0];

   // ALU control decode
   always_comb begin
      alu_op = ALU_ADD;
      case (ex_ALUOp)
         2'b01: alu_op = ALU_SUB;
         2'b10: begin
            case (funct3)
               // I-type ADDI may carry imm[10]=1 in the funct7[5] position
               3'b000: alu_op = (funct7_5 && ex_opcode == OPC_RTYPE) ? ALU_SUB : ALU_ADD;
               3'b001: alu_op = ALU_SLL;
               3'b010: alu_op = ALU_SLT;
               3'b011: alu_op = ALU_SLTU;
               3'b100: alu_op = ALU_XOR;
               3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110: alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
         end
         default: alu_op = ALU_ADD;
      endcase
   end

   // ALU
   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_ADD:  alu_result = fwd_a + op_b;
         ALU_SUB:  alu_result = fwd_a - op_b;
         ALU_SLL:  alu_result = fwd_a << shamt;
         ALU_SLT:  alu_result = {{(WORD_BITWIDTH-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
         ALU_SLTU: alu_result = {{(WORD_BITWIDTH-1){1'b0}}, fwd_a < op_b};
         ALU_XOR:  alu_result = fwd_a ^ op_b;
         ALU_SRL:  alu_result = fwd_a >> shamt;
         ALU_SRA:  alu_result = $unsigned($signed(fwd_a) >>> shamt);
         ALU_OR:   alu_result = fwd_a | op_b;
         ALU_AND:  alu_result = fwd_a & op_b;
         default:  alu_result = '0;
      endcase
   end

   // Branch condition always compares the two register operands, never imm
   assign eq   = (fwd_a == fwd_b);
   assign lt_s = ($signed(fwd_a) < $signed(fwd_b));
   assign lt_u = (fwd_a < fwd_b);

   always_comb begin
      cond = 1'b0;
      case (funct3)
         3'b000:  cond = eq;
         3'b001:  cond = !eq;
         3'b100:  cond = lt_s;
         3'b101:  cond = !lt_s;
         3'b110:  cond = lt_u;
         3'b111:  cond = !lt_u;
         default: cond = 1'b0;
      endcase
   end

   // EX/MEM register. Flush clears only control so a squashed slot has no
   // side effects; data fields load regardless.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_aluResult     <= '0;
         mem_storeData     <= '0;
         mem_zero          <= 1'b0;
         mem_branchTaken   <= 1'b0;
         mem_branchTarget  <= '0;
         mem_wt_branch     <= 1'b0;
         mem_wt_memRead    <= 1'b0;
         mem_wt_memToReg   <= 1'b0;
         mem_wt_memWrite   <= 1'b0;
         mem_wt_regWrite   <= 1'b0;
         mem_wt_regToWrite <= '0;
      end else begin
         mem_aluResult     <= alu_result;
         mem_storeData     <= fwd_b;
         mem_zero          <= (alu_result == '0);
         mem_branchTarget  <= ex_pc + ex_imm;
         mem_wt_regToWrite <= ex_wt_regToWrite;
         if (flush) begin
            mem_branchTaken <= 1'b0;
            mem_wt_branch   <= 1'b0;
            mem_wt_memRead  <= 1'b0;
            mem_wt_memToReg <= 1'b0;
            mem_wt_memWrite <= 1'b0;
            mem_wt_regWrite <= 1'b0;
         end else begin
            mem_branchTaken <= ex_wt_branch && cond;
            mem_wt_branch   <= ex_wt_branch;
            mem_wt_memRead  <= ex_wt_memRead;
            mem_wt_memToReg <= ex_wt_memToReg;
            mem_wt_memWrite <= ex_wt_memWrite;
            mem_wt_regWrite <= ex_wt_regWrite;
         end
      end
   end

endmodule
